// File: rtl/riscv_m_pkg.sv
// Shared constants for the RV32M multiply/divide unit: operand width,
// funct3 opcodes, FSM state encoding and the special-case result values.
package riscv_m_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [XLEN-1:0] DIV_BY_ZERO_Q = 32'hFFFFFFFF;
  localparam logic [XLEN-1:0] INT_MIN       = 32'h80000000;

endpackage

// File: rtl/muldiv_sign_fix.sv
// Combinational sign handling: operand-to-magnitude conversion on the way in,
// result negation, special cases and result selection on the way out.
module muldiv_sign_fix
  import riscv_m_pkg::*;
(
  input  logic [2:0]      f3_in_i,
  input  logic [XLEN-1:0] op_a_i,
  input  logic [XLEN-1:0] op_b_i,
  output logic [XLEN-1:0] a_mag_o,
  output logic [XLEN-1:0] b_mag_o,
  output logic            sa_o,
  output logic            sb_o,
  input  logic [2:0]      f3_q_i,
  input  logic            sa_q_i,
  input  logic            sb_q_i,
  input  logic [XLEN-1:0] a_raw_i,
  input  logic [XLEN-1:0] b_mag_q_i,
  input  logic [2*XLEN-1:0] acc_i,
  output logic [XLEN-1:0] result_o
);

  logic            a_signed, b_signed;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0] quo, rem;
  logic            div_zero, div_ovf;

  always_comb begin
    a_signed = (f3_in_i == F3_MULH) || (f3_in_i == F3_MULHSU) ||
               (f3_in_i == F3_DIV)  || (f3_in_i == F3_REM);
    b_signed = (f3_in_i == F3_MULH) || (f3_in_i == F3_DIV) || (f3_in_i == F3_REM);
    sa_o     = a_signed & op_a_i[XLEN-1];
    sb_o     = b_signed & op_b_i[XLEN-1];
    a_mag_o  = sa_o ? -op_a_i : op_a_i;
    b_mag_o  = sb_o ? -op_b_i : op_b_i;
  end

  // For division acc holds {remainder, quotient}; for multiply the full product.
  always_comb begin
    prod     = (sa_q_i ^ sb_q_i) ? -acc_i : acc_i;
    quo      = (sa_q_i ^ sb_q_i) ? -acc_i[XLEN-1:0] : acc_i[XLEN-1:0];
    rem      = sa_q_i ? -acc_i[2*XLEN-1:XLEN] : acc_i[2*XLEN-1:XLEN];
    div_zero = (b_mag_q_i == '0);
    div_ovf  = (f3_q_i == F3_DIV) && (a_raw_i == INT_MIN) && sb_q_i &&
               (b_mag_q_i == 32'd1);
    case (f3_q_i)
      F3_MUL:                       result_o = prod[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: result_o = prod[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:              result_o = div_zero ? DIV_BY_ZERO_Q :
                                               (div_ovf ? INT_MIN : quo);
      default:                      result_o = div_zero ? a_raw_i :
                                               (div_ovf ? '0 : rem);
    endcase
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: 32 shift-add or restoring-division
// steps, then a single-cycle register file write request.
module muldiv_unit
  import riscv_m_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [4:0]      rd,
  output logic            busy,
  output logic            done,
  output logic            reg_wr,
  output logic [4:0]      waddr,
  output logic [XLEN-1:0] wdata,
  output state_e          dbg_state
);

  state_e            state_q;
  logic [4:0]        cnt_q;
  logic [2:0]        f3_q;
  logic [4:0]        rd_q;
  logic [XLEN-1:0]   a_mag_q, b_mag_q, a_raw_q;
  logic              sa_q, sb_q;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic              busy_q, done_q, reg_wr_q;
  logic [4:0]        waddr_q;
  logic [XLEN-1:0]   wdata_q;

  logic [XLEN-1:0]   a_mag_in, b_mag_in, result;
  logic              sa_in, sb_in;
  logic [XLEN:0]     rem_sh;

  muldiv_sign_fix u_sign_fix (
    .f3_in_i   (funct3),
    .op_a_i    (op_a),
    .op_b_i    (op_b),
    .a_mag_o   (a_mag_in),
    .b_mag_o   (b_mag_in),
    .sa_o      (sa_in),
    .sb_o      (sb_in),
    .f3_q_i    (f3_q),
    .sa_q_i    (sa_q),
    .sb_q_i    (sb_q),
    .a_raw_i   (a_raw_q),
    .b_mag_q_i (b_mag_q),
    .acc_i     (acc_d),
    .result_o  (result)
  );

  // Division consumes dividend bits MSB first; the final step feeds result directly.
  always_comb begin
    acc_d  = acc_q;
    rem_sh = {acc_q[2*XLEN-1:XLEN], a_mag_q[5'd31 - cnt_q]};
    if (state_q == S_CALC) begin
      if (f3_q[2]) begin
        if (rem_sh >= {1'b0, b_mag_q})
          acc_d = {rem_sh[XLEN-1:0] - b_mag_q, acc_q[XLEN-2:0], 1'b1};
        else
          acc_d = {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
      end else if (b_mag_q[cnt_q]) begin
        acc_d = acc_q + ({{XLEN{1'b0}}, a_mag_q} << cnt_q);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      f3_q     <= '0;
      rd_q     <= '0;
      a_mag_q  <= '0;
      b_mag_q  <= '0;
      a_raw_q  <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      acc_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      reg_wr_q <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (start) begin
          state_q <= S_CALC;
          busy_q  <= 1'b1;
          f3_q    <= funct3;
          rd_q    <= rd;
          a_mag_q <= a_mag_in;
          b_mag_q <= b_mag_in;
          a_raw_q <= op_a;
          sa_q    <= sa_in;
          sb_q    <= sb_in;
          acc_q   <= '0;
          cnt_q   <= '0;
        end
        S_CALC: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            state_q  <= S_DONE;
            done_q   <= 1'b1;
            reg_wr_q <= (rd_q != 5'd0);
            waddr_q  <= rd_q;
            wdata_q  <= result;
          end
        end
        S_DONE: begin
          state_q  <= S_IDLE;
          busy_q   <= 1'b0;
          done_q   <= 1'b0;
          reg_wr_q <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign reg_wr    = reg_wr_q;
  assign waddr     = waddr_q;
  assign wdata     = wdata_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit: drivers push expected write requests,
// a negedge monitor pops and compares whenever done is presented.
module tb_muldiv_unit;
  import riscv_m_pkg::*;

  // Handshake: start is sampled only while idle; each accepted op yields exactly
  // one done pulse 32 edges later carrying wdata/waddr/reg_wr for that op.

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] op_a = '0, op_b = '0;
  logic [4:0]  rd = '0;
  logic        busy, done, reg_wr;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  state_e      dbg_state;

  muldiv_unit dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .funct3    (funct3),
    .op_a      (op_a),
    .op_b      (op_b),
    .rd        (rd),
    .busy      (busy),
    .done      (done),
    .reg_wr    (reg_wr),
    .waddr     (waddr),
    .wdata     (wdata),
    .dbg_state (dbg_state)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard
  logic [31:0] exp_q[$];
  logic [4:0]  exp_addr_q[$];
  logic        exp_wr_q[$];
  int unsigned exp_cyc_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  logic prev_done = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      if (prev_done) check("done_width", {31'b0, done}, 32'd0);
      if (done) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done: got done=1 wdata=0x%08h expected no completion", wdata);
        end else begin
          check("wdata", wdata, exp_q.pop_front());
          check("waddr", {27'b0, waddr}, {27'b0, exp_addr_q.pop_front()});
          check("reg_wr", {31'b0, reg_wr}, {31'b0, exp_wr_q.pop_front()});
          check("latency", cyc, exp_cyc_q.pop_front());
        end
      end else if (reg_wr) begin
        check("reg_wr_without_done", {31'b0, reg_wr}, 32'd0);
      end
    end
    prev_done = done;
  end

  // Drivers
  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] r, input logic [31:0] exp);
    @(negedge clk);
    start = 1'b1; funct3 = f; op_a = a; op_b = b; rd = r;
    @(posedge clk);
    #1;
    exp_q.push_back(exp);
    exp_addr_q.push_back(r);
    exp_wr_q.push_back(r != 5'd0);
    exp_cyc_q.push_back(cyc + 32);
    start  = 1'b0;
    op_a   = $urandom;
    op_b   = $urandom;
    funct3 = 3'($urandom_range(0, 7));
    rd     = 5'($urandom_range(0, 31));
  endtask

  task automatic wait_idle();
    int i;
    for (i = 0; i < 60; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy) break;
    end
    if (i == 60) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout: got %0d pending results expected 0", exp_q.size());
      exp_q.delete(); exp_addr_q.delete(); exp_wr_q.delete(); exp_cyc_q.delete();
    end
  endtask

  task automatic run(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                     input logic [4:0] r, input logic [31:0] exp);
    issue(f, a, b, r, exp);
    wait_idle();
  endtask

  initial begin
    #2;
    check("rst_busy",   {31'b0, busy},   32'd0);
    check("rst_done",   {31'b0, done},   32'd0);
    check("rst_reg_wr", {31'b0, reg_wr}, 32'd0);
    check("rst_waddr",  {27'b0, waddr},  32'd0);
    check("rst_wdata",  wdata,           32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;

    run(F3_MUL,    32'd7,        32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB);
    run(F3_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6,  32'hFFFFFFFE);
    run(F3_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7,  32'hFFFFFFFF);
    run(F3_MULH,   32'h80000000, 32'h80000000, 5'd8,  32'h40000000);
    run(F3_DIV,    32'hFFFFFFF9, 32'd2,        5'd10, 32'hFFFFFFFD);
    run(F3_REM,    32'hFFFFFFF9, 32'd2,        5'd11, 32'hFFFFFFFF);
    run(F3_DIVU,   32'd100,      32'd7,        5'd12, 32'd14);
    run(F3_REMU,   32'd100,      32'd7,        5'd13, 32'd2);
    run(F3_DIVU,   32'h1234,     32'd0,        5'd14, 32'hFFFFFFFF);
    run(F3_REM,    32'h1234,     32'd0,        5'd15, 32'h1234);
    run(F3_DIV,    32'h80000000, 32'hFFFFFFFF, 5'd16, 32'h80000000);
    run(F3_REM,    32'h80000000, 32'hFFFFFFFF, 5'd17, 32'd0);
    run(F3_MUL,    32'd3,        32'd4,        5'd0,  32'd12);

    // Starts at T0+5 and T0+32 must be ignored
    issue(F3_MUL, 32'd6, 32'd9, 5'd9, 32'd54);
    repeat (4) @(posedge clk);
    @(negedge clk);
    start = 1'b1; funct3 = F3_DIVU; op_a = 32'd50; op_b = 32'd5; rd = 5'd20;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (26) @(posedge clk);
    @(negedge clk);
    start = 1'b1; funct3 = F3_DIVU; op_a = 32'd60; op_b = 32'd5; rd = 5'd21;
    @(posedge clk);
    #1 start = 1'b0;
    check("busy_in_done", {31'b0, busy}, 32'd1);
    wait_idle();
    repeat (40) @(negedge clk);
    check("idle_after_ignored", {30'b0, dbg_state}, {30'b0, S_IDLE});

    // Reset at T0+10 aborts the op with no write
    @(negedge clk);
    start = 1'b1; funct3 = F3_MUL; op_a = 32'd5; op_b = 32'd5; rd = 5'd3;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check("abort_busy",   {31'b0, busy},   32'd0);
    check("abort_done",   {31'b0, done},   32'd0);
    check("abort_reg_wr", {31'b0, reg_wr}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (40) @(negedge clk);
    run(F3_MULHU, 32'h00010000, 32'h00010000, 5'd4, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test expected completion before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide execution unit. It sits between the register file read ports and the register file write port. It takes rs1/rs2 operands (rdata1/rdata2) plus the destination register, computes one of the eight M-extension operations over a fixed 32-cycle iteration, and drives a one-cycle write request (reg_wr/waddr/wdata) back into the register file.

## Interface
- XLEN, 32, operand/result width; only 32 is supported.
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low (0 = reset), one clock domain.
- start  in  1  request; sampled only in IDLE.
- funct3  in  3  op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- op_a  in  XLEN  rs1 value (from rdata1).
- op_b  in  XLEN  rs2 value (from rdata2).
- rd  in  5  destination register index.
- busy  out  1  high in CALC and DONE.
- done  out  1  one-cycle completion pulse.
- reg_wr  out  1  register file write enable.
- waddr  out  5  register file write address.
- wdata  out  XLEN  result.

## Operation
- States:
  - IDLE → CALC on start.
  - CALC → DONE after 32 iterations.
  - DONE → IDLE unconditionally.
- IDLE, start=1:
  - Latch funct3 and rd.
  - Latch operand magnitudes and sign flags. A is signed for MULH, MULHSU, DIV, REM; B is signed for MULH, DIV, REM.
  - Clear 64-bit accumulator; iteration counter = 0.
- CALC, multiply: shift-add one multiplier bit per cycle, producing a 64-bit unsigned product of magnitudes.
- CALC, divide: restoring division, one quotient bit per cycle, over the magnitudes.
- Counter is 5 bits; leave CALC when the counter is 31 at the clock edge.
- DONE: apply sign fix-up, then select the result.
  - MUL: low 32 bits.
  - MULH/MULHSU/MULHU: high 32 bits.
  - DIV/DIVU: quotient. REM/REMU: remainder.
  - Product sign = sA XOR sB. Quotient sign = sA XOR sB. Remainder sign = sA.
- Special cases (applied in DONE; latency unchanged):
  - Divide by zero: quotient = 0xFFFFFFFF; remainder = op_a as latched.
  - Signed overflow (0x80000000 / 0xFFFFFFFF, DIV): quotient = 0x80000000, remainder = 0.
- DONE outputs:
  - done=1; wdata = result; waddr = latched rd.
  - reg_wr = 1 only if latched rd ≠ 0. done still pulses when rd = 0.
- Outside DONE: done=0, reg_wr=0. wdata and waddr hold their last values.
- start is ignored while busy, including during DONE. No queueing.

## Timing
- Reset (asynchronous assert) sets: state IDLE, busy=0, done=0, reg_wr=0, waddr=0, wdata=0. Counter and accumulator are also cleared.
- Reset deassertion is synchronised externally; the first active edge after release sees IDLE.
- Latency: start is sampled at edge T0. done, reg_wr and the result are valid from edge T0+32 to edge T0+33. The next start is accepted at edge T0+33.
- Throughput: one op per 33 cycles.
- All outputs are registered. wdata, waddr and reg_wr are stable for the whole DONE cycle, so the register file's falling-edge write captures them mid-cycle.
- op_a, op_b, funct3 and rd are sampled only at the accepting edge and may change afterwards.
- Reset mid-CALC or mid-DONE aborts immediately: no write is issued and no done pulse occurs.

## Structure
- Package riscv_m_pkg holds:
  - XLEN.
  - funct3 constants (F3_MUL … F3_REMU).
  - State encoding (S_IDLE, S_CALC, S_DONE).
  - DIV_BY_ZERO_Q = 32'hFFFFFFFF and INT_MIN = 32'h80000000.
- One sub-module, muldiv_sign_fix: combinational.
  - Input side: operand-to-magnitude conversion.
  - Output side: result negation and selection.
  - Instanced twice, or once with both functions.
- The FSM, counter and datapath registers live in muldiv_unit.

## Test plan
- MUL 7 × 0xFFFFFFFD, rd=5 → wdata 0xFFFFFFEB, waddr 5, reg_wr and done high exactly one cycle, 32 cycles after start.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE; MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF; MULH 0x80000000 × 0x80000000 → 0x40000000.
- DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD; REM same operands → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2.
- DIVU 0x1234 / 0 → 0xFFFFFFFF; REM 0x1234 / 0 → 0x1234; DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM same operands → 0.
- Second start pulsed at T0+5 and at T0+32 → ignored: a single done only. Op with rd=0 → done pulses, reg_wr stays 0.
- reset=0 at T0+10 during CALC → busy, done and reg_wr are 0 immediately; no write occurs; a new start after release completes normally.
